seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

- Time-multiplexed seven-segment display controller:
  - holds one code per digit;
  - scans the digits onto a single shared active-low segment bus, with a blanking gap between digits to suppress ghosting;
  - generates a paced step pulse for the application state machine.
- Sits between the application FSM and the board display pins.
- Replaces per-design divided clocks with a single-clock enable scheme.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (2..8).
- SCAN_DIV, 20000: clk cycles per digit slot (blank + show).
- BLANK_CYC, 100: blanked cycles at the start of each slot; 1 <= BLANK_CYC < SCAN_DIV.
- STEP_DIV, 20000000: clk cycles per step_tick period (>= 2).

Ports:
- clk  in  1  system clock (Sys_Clk0 domain).
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write strobe for the digit register file.
- wr_idx  in  3  digit index to write; values >= DIGITS are ignored.
- wr_code  in  5  0x00–0x0F: hex digit; 0x10–0x1F: digit blank.
- step_en  in  1  step counter runs while high, holds while low.
- seg  out  7  {a,b,c,d,e,f,g}; active-low; registered.
- an  out  DIGITS  digit enables; active-low; one-hot-low or all-high; registered.
- step_tick  out  1  one-cycle pulse per STEP_DIV enabled cycles; registered.

## Operation
- Register file:
  - DIGITS entries × 5 bits.
  - A write with wr_en=1 and wr_idx < DIGITS updates the entry at that clock edge.
- Scan FSM states:
  - BLANK: an = all ones, seg = 7'b1111111. Lasts BLANK_CYC cycles, then goes to SHOW.
  - SHOW: an[idx] = 0, all other an bits = 1, seg = decode(reg[idx]). Lasts SCAN_DIV − BLANK_CYC cycles.
  - On leaving SHOW: idx ← idx+1, wrapping DIGITS−1 → 0, then go to BLANK.
- Decode, active-low a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - Any code with bit4 = 1 decodes to 1111111.
- Step counter:
  - Counts 0..STEP_DIV−1 only while step_en = 1, then wraps to 0.
  - step_tick = 1 for exactly the cycle after the counter reaches STEP_DIV−1.
  - step_en = 0 holds the count and gives step_tick = 0.
- Reset (rst_n low at an edge):
  - all register-file entries ← 0x10 (blank);
  - state ← BLANK, idx ← 0, slot and step counters ← 0;
  - seg = 7'h7F, an = all ones, step_tick = 0.
- Mid-operation reset aborts the current slot. The first SHOW after release is digit 0.

## Timing
- Slot counter is 0-based within the slot:
  - BLANK on counts 0..BLANK_CYC−1;
  - SHOW on counts BLANK_CYC..SCAN_DIV−1.
- Outputs are registered: seg/an reflect the state and count of the previous cycle (1-cycle latency).
- Full refresh period: DIGITS × SCAN_DIV cycles. First SHOW of digit 0 appears on an at cycle BLANK_CYC+1 after reset release.
- Write to the currently shown digit at edge k: register updates at k, seg shows the new code at edge k+1. No tearing inside BLANK.
- Write and scan of the same index in the same cycle: the scan path sees the old value that cycle and the new value the next.
- Write with wr_idx >= DIGITS: no state change.
- Back-to-back writes are accepted every cycle; last write wins.
- step_tick period is exactly STEP_DIV cycles while step_en stays high. Deasserting step_en on the terminal count suppresses that tick.

## Structure
- Package seg_pkg:
  - scan state enum {BLANK, SHOW};
  - SEG_BLANK = 7'h7F;
  - CODE_BLANK = 5'h10;
  - 16-entry hex-to-segment constant table.
- Sub-module seg_hex_decode: combinational 5-bit code → 7-bit active-low segments, using the seg_pkg table. Shared with other display blocks.
- Top holds the register file, slot counter, scan FSM, digit index, step counter and output registers.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, STEP_DIV=5.
1. Reset, then idle 40 cycles: seg = 7F throughout; an pattern 1111 (2 cycles), 1110 (6 cycles), 1111, 1101, …; wraps to digit 0 after 32 cycles.
2. Write 0..3 ← codes 1, 2, 3, 4: during each digit's SHOW, seg = 1001111, 0010010, 0000110, 1001100 respectively; seg = 7F during BLANK.
3. Write digit 0 ← 0x8 mid-SHOW of digit 0: seg changes 1001111 → 0000000 exactly one cycle after the write edge. Then write wr_idx=5: no register changes.
4. step_en = 1 for 20 cycles: step_tick pulses at cycles 5, 10, 15, 20. Drop step_en for 3 cycles before the terminal count: the tick is delayed by exactly 3 cycles.
5. rst_n low for 1 cycle during SHOW of digit 2: next cycle an = 1111, seg = 7F; all digits read blank; the scan restarts at digit 0 after 2 BLANK cycles.
6. Write code 0x1A to digit 1: digit 1 SHOW gives an = 1101 with seg = 7F (blank code, not the hex decode).

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment display blocks
package seg_pkg;
    typedef enum logic {BLANK, SHOW} scan_state_t;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 5-bit digit code to active-low a..g segments; bit4 set means blank
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);
    assign seg = code[4] ? SEG_BLANK : HEX_SEG[code[3:0]];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with blanking gap and paced step tick
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 20000,
    parameter int BLANK_CYC = 100,
    parameter int STEP_DIV  = 20000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [4:0]        wr_code,
    input  logic              step_en,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              step_tick
);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(STEP_DIV);

    logic [4:0]        regs [DIGITS];
    scan_state_t       state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [SW-1:0]     step_cnt;
    logic [6:0]        dec_seg, seg_nxt;
    logic [DIGITS-1:0] an_nxt;

    seg_hex_decode u_dec (
        .code(regs[idx]),
        .seg (dec_seg)
    );

    // Digit register file; out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) regs[i] <= CODE_BLANK;
        end else if (wr_en && int'(wr_idx) < DIGITS) begin
            regs[wr_idx[IW-1:0]] <= wr_code;
        end
    end

    // Slot sequencing: blank gap first, then show, then advance to the next digit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        if (state == SHOW && cnt == CW'(SCAN_DIV - 1)) begin
            cnt_nxt   = '0;
            state_nxt = BLANK;
            idx_nxt   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
            state_nxt = SHOW;
        end
        an_nxt  = (state == SHOW) ? ~(DIGITS'(1) << idx) : '1;
        seg_nxt = (state == SHOW) ? dec_seg : SEG_BLANK;
    end

    // Scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= SEG_BLANK;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            an    <= an_nxt;
            seg   <= seg_nxt;
        end
    end

    // Step pacing: counter only advances while enabled, tick fires after the terminal count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt  <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= step_en && step_cnt == SW'(STEP_DIV - 1);
            if (step_en) step_cnt <= (step_cnt == SW'(STEP_DIV - 1)) ? '0 : step_cnt + 1'b1;
        end
    end
endmodule
